// File: rtl/imem_loader.sv
// Instruction memory with NOP clear sweep after reset and big-endian byte-stream program loader.
// Read latency 1 cycle; load_ready is high only in LOAD, and busy stalls fetch while clearing or loading.
module imem_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hF800_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [31:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_oor,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [ADDR_W:0]     wr_ptr;
  logic [CNT_W-1:0]    byte_cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   asm_next;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                byte_acc;
  logic                word_done;
  logic                load_full;
  logic                rd_in_range;
  logic                wr_in_range;
  logic                cpu_wr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                unused_ok;

  assign unused_ok = ^{rd_addr[1:0], wr_addr[1:0]};

  assign load_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);

  assign rd_in_range = (rd_addr[31:ADDR_W+2] == '0);
  assign wr_in_range = (wr_addr[31:ADDR_W+2] == '0);
  assign cpu_wr      = (state_q == IDLE) && wr_en && wr_in_range && !load_start;

  // Each byte lands at its final big-endian lane, so a short last word is zero-padded for free.
  assign byte_acc  = (state_q == LOAD) && load_valid;
  assign cnt_inc   = CNT_W'(byte_cnt + 1'b1);
  assign word_done = byte_acc && ((cnt_inc == CNT_W'(BYTES)) || load_last);
  assign asm_next  = asm_q | ({load_byte, {(DATA_W-8){1'b0}}} >> {byte_cnt, 3'b000});
  assign load_full = wr_ptr[ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_ptr == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (load_valid && load_last) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep, CPU writes and the loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = NOP_WORD;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
      end
      IDLE: if (cpu_wr) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr[ADDR_W+1:2];
        mem_wdata = wr_data;
      end
      LOAD: if (word_done && !load_full) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr[ADDR_W-1:0];
        mem_wdata = asm_next;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_ptr   <= '0;
      wr_ptr    <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= byte_acc && load_last;
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state_q == IDLE && load_start) begin
        wr_ptr   <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
        load_err <= 1'b0;
      end else if (byte_acc) begin
        if (word_done) begin
          byte_cnt <= '0;
          asm_q    <= '0;
          // Pointer parks at DEPTH so every further word is flagged rather than wrapped.
          if (load_full) load_err <= 1'b1;
          else           wr_ptr   <= wr_ptr + 1'b1;
        end else begin
          byte_cnt <= cnt_inc;
          asm_q    <= asm_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= NOP_WORD;
      rd_oor  <= 1'b0;
    end else if (rd_en) begin
      rd_oor  <= !rd_in_range;
      rd_data <= (!rd_in_range || busy) ? NOP_WORD : mem[rd_addr[ADDR_W+1:2]];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand sequences and randomized traffic vs. a word-array model.
module tb_imem_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_oor;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic        busy;

  imem_loader dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_oor(rd_oor),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  prog [$];
  logic [31:0] last_d;
  logic        last_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_d;
    logic        exp_o;
  } rd_vec_t;
  rd_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic o);
    o = (addr >= 32'(DEPTH * 4));
    d = o ? NOP : ref_mem[addr[7:2]];
  endtask

  task automatic do_read_exp(input logic [31:0] addr, input logic [31:0] exp_d,
                             input logic exp_o, input string name);
    rd_en   = 1'b1;
    rd_addr = addr;
    @(negedge clk);
    rd_en  = 1'b0;
    last_d = exp_d;
    last_o = exp_o;
    chk({name, "_data"}, rd_data, exp_d);
    chk({name, "_oor"}, rd_oor, exp_o);
  endtask

  task automatic do_read(input logic [31:0] addr, input string name);
    logic [31:0] d;
    logic        o;
    model_read(addr, d, o);
    do_read_exp(addr, d, o, name);
  endtask

  task automatic readback_all(input string name);
    for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4), name);
  endtask

  // Program image: word w is bytes 4w..4w+3 big-endian, missing trailing bytes are zero.
  task automatic apply_prog_to_model();
    int nw;
    logic [31:0] w;
    nw = (prog.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < prog.size()) w = w | (32'(prog[4 * i + b]) << (24 - 8 * b));
      if (i < DEPTH) ref_mem[i] = w;
    end
  endtask

  task automatic run_load(input bit stall, input bit wr_clash);
    int  idx = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    bit  acc;
    load_start = 1'b1;
    if (wr_clash) begin
      wr_en   = 1'b1;
      wr_addr = 32'hC;
      wr_data = 32'h1234_5678;
    end
    @(negedge clk);
    load_start = 1'b0;
    wr_en      = 1'b0;
    chk("ready_rise", load_ready, 1);
    chk("err_cleared", load_err, 0);
    chk("busy_in_load", busy, 1);
    while (idx < prog.size() && cyc < 5000) begin
      load_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_byte  = prog[idx];
      load_last  = (idx == prog.size() - 1);
      acc        = load_valid && load_ready;
      @(negedge clk);
      cyc++;
      if (load_done) done_cnt++;
      if (acc) idx++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (load_done) done_cnt++;
    end
    chk("bytes_accepted", idx, prog.size());
    chk("done_pulses", done_cnt, 1);
    chk("ready_fall", load_ready, 0);
    chk("busy_after_load", busy, 0);
    chk("load_err", load_err, ((prog.size() + 3) / 4 > DEPTH) ? 1 : 0);
    apply_prog_to_model();
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, n, DEPTH);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, NOP, 1'b0};
    vecs[1] = '{32'h0000_0004, NOP, 1'b0};
    vecs[2] = '{32'h0000_00FC, NOP, 1'b0};
    vecs[3] = '{32'h0000_0100, NOP, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, NOP, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_rd_data", rd_data, NOP);
    chk("rst_rd_oor", rd_oor, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    wait_clear("clear_cycles");

    for (int i = 0; i < 5; i++) do_read_exp(vecs[i].addr, vecs[i].exp_d, vecs[i].exp_o, "vec_rd");
    rd_addr = 32'h0000_0008;
    @(negedge clk);
    chk("hold_data", rd_data, last_d);
    chk("hold_oor", rd_oor, last_o);

    prog = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load(1'b0, 1'b0);
    do_read_exp(32'h0, 32'h0011_2233, 1'b0, "load8_w0");
    do_read_exp(32'h4, 32'h4455_6677, 1'b0, "load8_w1");

    prog = '{8'hAA, 8'hBB};
    run_load(1'b0, 1'b0);
    do_read_exp(32'h0, 32'hAABB_0000, 1'b0, "partial_w0");
    do_read(32'h4, "partial_w1");

    wr_en   = 1'b1;
    wr_addr = 32'h8;
    wr_data = 32'hDEAD_BEEF;
    rd_en   = 1'b1;
    rd_addr = 32'h8;
    last_d  = ref_mem[2];
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rbw_old", rd_data, last_d);
    ref_mem[2] = 32'hDEAD_BEEF;
    do_read_exp(32'h8, 32'hDEAD_BEEF, 1'b0, "rbw_new");

    wr_en   = 1'b1;
    wr_addr = 32'h100;
    wr_data = 32'h1111_1111;
    @(negedge clk);
    wr_en = 1'b0;
    do_read(32'h0, "oor_wr_dropped");

    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1'b0, 1'b1);
    do_read(32'hC, "clash_wr_dropped");
    do_read_exp(32'h0, 32'h0102_0304, 1'b0, "clash_load");

    prog.delete();
    for (int i = 0; i < int'($urandom_range(1, 80)); i++) prog.push_back(8'($urandom));
    run_load(1'b1, 1'b0);
    readback_all("stall_load");

    do_read(32'h0, "rnd_prime");
    for (int k = 0; k < 150; k++) begin
      logic [31:0] d;
      logic        o;
      bit          we;
      bit          re;
      we      = 1'($urandom_range(0, 1));
      re      = 1'($urandom_range(0, 1));
      wr_en   = we;
      wr_addr = 32'($urandom_range(0, 71)) * 4;
      wr_data = $urandom;
      rd_en   = re;
      rd_addr = (32'($urandom_range(0, 71)) * 4) | 32'($urandom_range(0, 3));
      if (re) begin
        model_read(rd_addr, d, o);
        last_d = d;
        last_o = o;
      end
      @(negedge clk);
      chk("rnd_rd_data", rd_data, last_d);
      chk("rnd_rd_oor", rd_oor, last_o);
      if (we && wr_addr < 32'(DEPTH * 4)) ref_mem[wr_addr[7:2]] = wr_data;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    prog.delete();
    for (int i = 0; i < (DEPTH + 1) * 4; i++) prog.push_back(8'($urandom));
    run_load(1'b1, 1'b0);
    readback_all("overflow");

    prog = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_byte  = prog[i];
      @(negedge clk);
    end
    load_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("abort_ready", load_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_rd_data", rd_data, NOP);
    @(negedge clk);
    reset_n = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 32'hFC;
    @(negedge clk);
    rd_en = 1'b0;
    chk("busy_rd_data", rd_data, NOP);
    chk("busy_rd_oor", rd_oor, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    begin
      int n = 1;
      while (busy && n < 200) begin
        @(posedge clk);
        #1 n++;
      end
      chk("reclear_cycles", n, DEPTH);
      @(negedge clk);
    end
    chk("reclear_err", load_err, 0);
    readback_all("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with a built-in clear sequencer and byte-stream program loader. Successor to the fixed 32×32 program memory: depth, word width and fill value are parameters; after reset it sweeps every location to NOP, then accepts a program as a big-endian byte stream over a valid/ready handshake. It sits between the fetch stage (registered read port addressed by PC) and the host/UART loader, and asserts BUSY so fetch stalls while clearing or loading.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; must be a power of two, 2 or more.
- ADDR_W, $clog2(DEPTH), word index width (derived).
- NOP_WORD, 32'hF800_0000, fill value written by clear and returned when not ready.
- CLK  in  1  single clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RD_EN  in  1  fetch read request.
- RD_ADDR  in  32  byte address (PC); word index = RD_ADDR[ADDR_W+1:2].
- RD_DATA  out  DATA_W  registered read data.
- RD_OOR  out  1  registered; the last accepted read was out of range (RD_ADDR ≥ DEPTH*4).
- WR_EN  in  1  direct CPU word write.
- WR_ADDR  in  32  byte address for WR_EN.
- WR_DATA  in  DATA_W  write data.
- LOAD_START  in  1  one-cycle pulse; starts a load at word 0.
- LOAD_VALID  in  1  byte valid.
- LOAD_BYTE  in  8  byte data.
- LOAD_LAST  in  1  qualifies the final byte of the program.
- LOAD_READY  out  1  byte accepted when LOAD_VALID && LOAD_READY.
- LOAD_DONE  out  1  one-cycle pulse at the end of a load.
- LOAD_ERR  out  1  sticky overflow flag; cleared by LOAD_START.
- BUSY  out  1  high in CLEAR or LOAD.

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- Reset values: state=CLEAR, clr_ptr=0, wr_ptr=0, byte_cnt=0, RD_DATA=NOP_WORD, RD_OOR=0, LOAD_READY=0, LOAD_DONE=0, LOAD_ERR=0, BUSY=1. Array contents are not reset directly.
- CLEAR: each cycle writes NOP_WORD to mem[clr_ptr], then increments clr_ptr. After writing DEPTH-1, the FSM moves to IDLE (DEPTH cycles total). LOAD_START, WR_EN and LOAD_VALID are ignored.
- IDLE: WR_EN with an in-range address writes mem[index]; an out-of-range address is dropped. LOAD_START moves the FSM to LOAD with wr_ptr=0, byte_cnt=0 and LOAD_ERR cleared. If LOAD_START and WR_EN occur in the same cycle, LOAD_START wins and the write is dropped.
- LOAD: LOAD_READY=1.
  - Each accepted byte shifts into the assembly register MSB-first (first byte → bits DATA_W-1:DATA_W-8), and byte_cnt increments.
  - When byte_cnt reaches DATA_W/8, or when a byte with LOAD_LAST is accepted, the assembled word is written to mem[wr_ptr]. A partial word is zero-padded in its low bytes. Then wr_ptr increments and byte_cnt resets to 0.
  - If wr_ptr has already written DEPTH words and another word completes, the write is suppressed and LOAD_ERR is set. wr_ptr does not wrap.
  - On the LOAD_LAST byte: LOAD_DONE pulses the next cycle, and the FSM moves to IDLE.
  - WR_EN and LOAD_START are ignored in LOAD.
- Read: on RD_EN, RD_DATA is updated the next edge.
  - If the address is out of range, or BUSY is high, RD_DATA=NOP_WORD.
  - Otherwise RD_DATA=mem[index].
  - RD_OOR=1 only for an out-of-range address. Without RD_EN, RD_DATA and RD_OOR hold.
- Read and write to the same index in the same cycle (IDLE): the read returns the old word (read-before-write).

## Timing
- Read latency: 1 cycle (RD_EN at edge n, data valid after edge n+1).
- Clear: DEPTH cycles after RESET_N rises. BUSY falls on the edge that enters IDLE.
- LOAD_READY rises the cycle after LOAD_START is sampled and falls the cycle after the LAST byte is accepted.
- Word write happens on the same edge that accepts the final byte of the word.
- Reset asserted mid-CLEAR or mid-LOAD aborts immediately: all outputs take reset values, and the clear sequence restarts after RESET_N rises.

## Test plan
- Reset then wait DEPTH cycles: BUSY=1 for exactly 64 cycles; then RD_EN at RD_ADDR=0x0, 0x4 and 0xFC each return 0xF800_0000.
- Load bytes 00 11 22 33 44 55 66 77 with LAST on 77: mem[0]=0x00112233, mem[1]=0x44556677, LOAD_DONE pulses once, BUSY falls.
- Partial load AA BB (LAST on BB): mem[0]=0xAABB0000.
- Handshake stalls: toggle LOAD_VALID randomly; result is identical to the continuous case.
- Overflow: load 65 words: LOAD_ERR=1, mem[63] holds the 64th word, and the 65th word is not written anywhere.
- Out-of-range read RD_ADDR=0x100: RD_DATA=0xF800_0000, RD_OOR=1.
- Reset during load: assert RESET_N low mid-word; after reset plus 64 cycles, all locations read NOP.
- IDLE WR_EN at 0x8 with 0xDEADBEEF, plus a simultaneous read of 0x8: that read returns the old value; the next read returns 0xDEADBEEF.
